// File: rtl/pwm_cfg_sequencer.sv
// APB-programmable configuration sequencer for the 3-channel PWM core.
// CPU writes land in shadow registers. They are forwarded to the core only
// at PWM period boundaries. An optional duty ramp gives soft start and soft stop.
module pwm_cfg_sequencer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [4:0]  paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    input  logic        period_end_i,
    output logic [2:0]  enable_o,
    output logic [31:0] prescaler_o,
    output logic [31:0] pwm_period_o,
    output logic [31:0] duty_cycle_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // Shadow (CPU-visible) registers.
    logic [2:0]  r_en_req;
    logic        r_ramp_en;
    logic [31:0] r_presc;
    logic [31:0] r_period;
    logic [31:0] r_duty_tgt;
    logic [31:0] r_step;
    logic        r_pending;

    // Sequencer state and values presented to the core.
    state_t      r_state;
    logic [2:0]  r_enable;
    logic [31:0] r_prescaler;
    logic [31:0] r_pwm_period;
    logic [31:0] r_duty;

    state_t      w_state_next;
    logic [2:0]  w_enable_next;
    logic [31:0] w_prescaler_next;
    logic [31:0] w_pwm_period_next;
    logic [31:0] w_duty_next;
    logic        w_apply;

    logic        w_wr;
    logic        w_cfg_wr;
    logic [2:0]  w_word;
    logic [31:0] w_target;
    logic [31:0] w_ramp_duty;
    logic [31:0] w_stop_duty;
    logic        w_stopping;
    logic        w_unused_addr_lsb;

    assign w_wr              = psel_i & penable_i & pwrite_i;
    assign w_word            = paddr_i[4:2];
    assign w_cfg_wr          = w_wr && (w_word <= 3'd4);
    assign w_unused_addr_lsb = ^paddr_i[1:0];

    // The core never gets a duty larger than its period.
    assign w_target   = (r_duty_tgt > r_period) ? r_period : r_duty_tgt;
    assign w_stopping = r_pending && (r_en_req == 3'd0);

    // One ramp step from cur toward tgt. The arithmetic is 33-bit so it cannot wrap.
    // A zero step lands on the target immediately.
    function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                                input logic [31:0] tgt,
                                                input logic [31:0] stp);
        logic [32:0] s;
        s = 33'd0;
        if (stp == 32'd0) begin
            return tgt;
        end
        if (cur < tgt) begin
            s = {1'b0, cur} + {1'b0, stp};
            return (s >= {1'b0, tgt}) ? tgt : s[31:0];
        end
        s = {1'b0, cur} - {1'b0, stp};
        return (s[32] || (s[31:0] <= tgt)) ? tgt : s[31:0];
    endfunction

    assign w_ramp_duty = step_toward(r_duty, w_target, r_step);
    assign w_stop_duty = step_toward(r_duty, 32'd0, r_step);

    assign pready_o     = 1'b1;
    assign enable_o     = r_enable;
    assign prescaler_o  = r_prescaler;
    assign pwm_period_o = r_pwm_period;
    assign duty_cycle_o = r_duty;

    // Read mux: registers straight to prdata, zero-wait-state APB.
    always_comb begin
        prdata_o = 32'd0;
        case (w_word)
            3'd0:    prdata_o = {23'd0, r_ramp_en, 5'd0, r_en_req};
            3'd1:    prdata_o = r_presc;
            3'd2:    prdata_o = r_period;
            3'd3:    prdata_o = r_duty_tgt;
            3'd4:    prdata_o = r_step;
            3'd5:    prdata_o = {27'd0, r_pending, 2'd0, r_state};
            default: prdata_o = 32'd0;
        endcase
    end

    // Shadow register writes. A write in the same cycle as an apply keeps
    // PENDING set, so that new value is picked up at the next boundary.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_en_req   <= 3'd0;
            r_ramp_en  <= 1'b0;
            r_presc    <= 32'd0;
            r_period   <= 32'd0;
            r_duty_tgt <= 32'd0;
            r_step     <= 32'd0;
            r_pending  <= 1'b0;
        end else begin
            if (w_wr) begin
                case (w_word)
                    3'd0: begin
                        r_en_req  <= pwdata_i[2:0];
                        r_ramp_en <= pwdata_i[8];
                    end
                    3'd1:    r_presc    <= pwdata_i;
                    3'd2:    r_period   <= pwdata_i;
                    3'd3:    r_duty_tgt <= pwdata_i;
                    3'd4:    r_step     <= pwdata_i;
                    default: ;
                endcase
            end
            if (w_cfg_wr) begin
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Sequencer next state. Outside IDLE, core outputs move only on period_end_i.
    always_comb begin
        w_state_next      = r_state;
        w_enable_next     = r_enable;
        w_prescaler_next  = r_prescaler;
        w_pwm_period_next = r_pwm_period;
        w_duty_next       = r_duty;
        w_apply           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_enable_next     = 3'd0;
                w_duty_next       = 32'd0;
                w_prescaler_next  = r_presc;
                w_pwm_period_next = r_period;
                if (r_en_req != 3'd0) begin
                    w_apply       = 1'b1;
                    w_enable_next = r_en_req;
                    if (r_ramp_en) begin
                        w_state_next = ST_RAMP;
                    end else begin
                        w_state_next = ST_RUN;
                        w_duty_next  = w_target;
                    end
                end
            end
            ST_RAMP: begin
                if (period_end_i) begin
                    if (r_pending) begin
                        w_apply           = 1'b1;
                        w_prescaler_next  = r_presc;
                        w_pwm_period_next = r_period;
                    end
                    if (w_stopping) begin
                        // Disable requested mid-ramp: stop softly, or drop at once.
                        if (r_ramp_en) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_state_next  = ST_IDLE;
                            w_enable_next = 3'd0;
                            w_duty_next   = 32'd0;
                        end
                    end else begin
                        if (r_pending) begin
                            w_enable_next = r_en_req;
                        end
                        w_duty_next = w_ramp_duty;
                        if (w_ramp_duty == w_target) begin
                            w_state_next = ST_RUN;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (period_end_i && r_pending) begin
                    w_apply           = 1'b1;
                    w_prescaler_next  = r_presc;
                    w_pwm_period_next = r_period;
                    if (r_en_req == 3'd0) begin
                        // Soft stop keeps the channels enabled while duty winds down.
                        if (r_ramp_en) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_state_next  = ST_IDLE;
                            w_enable_next = 3'd0;
                            w_duty_next   = 32'd0;
                        end
                    end else begin
                        w_enable_next = r_en_req;
                        if (w_target != r_duty) begin
                            if (r_ramp_en) begin
                                w_state_next = ST_RAMP;
                            end else begin
                                w_duty_next = w_target;
                            end
                        end
                    end
                end
            end
            ST_STOP: begin
                if (period_end_i) begin
                    if (r_en_req != 3'd0) begin
                        // Re-enabled during soft stop: ramp back up from where we are.
                        w_apply           = 1'b1;
                        w_prescaler_next  = r_presc;
                        w_pwm_period_next = r_period;
                        w_enable_next     = r_en_req;
                        w_state_next      = ST_RAMP;
                    end else begin
                        w_duty_next = w_stop_duty;
                        if (w_stop_duty == 32'd0) begin
                            w_state_next  = ST_IDLE;
                            w_enable_next = 3'd0;
                        end
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Sequencer state and core-facing output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_enable     <= 3'd0;
            r_prescaler  <= 32'd0;
            r_pwm_period <= 32'd0;
            r_duty       <= 32'd0;
        end else begin
            r_state      <= w_state_next;
            r_enable     <= w_enable_next;
            r_prescaler  <= w_prescaler_next;
            r_pwm_period <= w_pwm_period_next;
            r_duty       <= w_duty_next;
        end
    end

endmodule

// File: doc/pwm_cfg_sequencer.md
# pwm_cfg_sequencer

Configuration and sequencing controller for the 3-channel PWM core (`top`: enable_i, prescaler_i, pwm_period_i, duty_cycle_i). It exposes an APB slave register file, holds CPU writes in shadow registers, and applies them to the PWM core only at PWM period boundaries. It also drives an optional soft-start/soft-stop duty ramp, so the core never sees a mid-period configuration change.

## Interface
- No parameters.
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- psel_i, penable_i, pwrite_i  in  1 each  APB control
- paddr_i  in  5  byte address; bits [1:0] ignored
- pwdata_i  in  32  APB write data
- prdata_o  out  32  APB read data; combinational from registers
- pready_o  out  1  tied 1
- period_end_i  in  1  one-cycle pulse from the PWM core on the last clk of each PWM period
- enable_o  out  3  to core enable_i
- prescaler_o  out  32  to core prescaler_i
- pwm_period_o  out  32  to core pwm_period_i
- duty_cycle_o  out  32  to core duty_cycle_i
- Clock is clk. Reset is rstn, asynchronous, active-low.

## Operation
- Registers. Each is written on `psel_i & penable_i & pwrite_i`, and updates at the next clk edge.
  - 0x00 CTRL: [2:0] EN_REQ, [8] RAMP_EN.
  - 0x04 PRESC.
  - 0x08 PERIOD.
  - 0x0C DUTY_TGT.
  - 0x10 STEP.
  - 0x14 STATUS (RO): [1:0] state (0 IDLE, 1 RAMP, 2 RUN, 3 STOP), [4] PENDING.
  - Other addresses read 0; writes to them are ignored.
- Any write to 0x00–0x10 sets PENDING.
- Apply event means copying PRESC→prescaler_o, PERIOD→pwm_period_o and EN_REQ→enable_o. Duty handling is per state, below.
- Applied duty target is min(DUTY_TGT, PERIOD), compared unsigned at 32 bits.
- FSM:
  - IDLE: enable_o=0 and duty_cycle_o=0. PRESC/PERIOD are applied every cycle. When EN_REQ≠0, apply and go to RAMP if RAMP_EN=1, else RUN with duty_cycle_o=target. PENDING clears.
  - RAMP: on each period_end_i, duty_cycle_o moves toward target by STEP. Rising uses min(duty+STEP, target); falling uses max(duty−STEP, target). Sums are computed at 33 bits, so no wrap. STEP=0 jumps straight to target. When duty equals target after the step, go to RUN.
  - RUN: if PENDING, on period_end_i apply. A changed target with RAMP_EN=1 goes to RAMP; otherwise duty is set directly. EN_REQ=0 goes to STOP if RAMP_EN=1, else to IDLE.
  - STOP: enable_o is held. Duty ramps down toward 0 by STEP per period_end_i. On the period_end_i where duty reaches 0, go to IDLE with enable_o=0. If EN_REQ≠0 is written while in STOP, go to RAMP toward the target at the next period_end_i.
- Simultaneous register write and period_end_i:
  - The apply uses the pre-write register values.
  - PENDING stays set, so the new value is applied at the following period_end_i.
- period_end_i in IDLE is ignored.

## Timing
- Reset values: enable_o=0, prescaler_o=0, pwm_period_o=0, duty_cycle_o=0, and all registers 0. State is IDLE, PENDING=0, prdata_o=0, pready_o=1.
- APB: zero wait states. A write is visible in prdata_o on the cycle after the access phase.
- Latency:
  - Write to output update is 1 clk in IDLE.
  - When running, outputs change on the clk edge that samples period_end_i=1, never at any other time.
- Reset mid-ramp: all outputs return to reset values asynchronously. No ramp state is retained.

## Test plan
1. Reset check: assert rstn=0 mid-RAMP → all outputs 0 immediately; STATUS=0 after release.
2. IDLE direct start:
   - Stimulus: PRESC=4, PERIOD=100, DUTY_TGT=30, RAMP_EN=0, then EN_REQ=3'b101.
   - Required: enable_o=5, duty=30, STATUS=RUN 1 clk after the CTRL write.
3. Ramp up:
   - Stimulus: PERIOD=100, DUTY_TGT=50, STEP=20, RAMP_EN=1, EN=7.
   - Required: duty 0 → 20 → 40 → 50 on successive period_end_i, then RUN.
   - STEP=0 repeat: duty jumps to 50 at the first period_end_i.
4. Shadowing in RUN:
   - Stimulus: write PERIOD=200 mid-period.
   - Required: pwm_period_o unchanged and PENDING=1 until period_end_i, then 200 and PENDING=0.
   - Same-cycle write case: a write in the same cycle as period_end_i takes effect one period later.
5. Clamp and ramp down:
   - Stimulus: DUTY_TGT=500 with PERIOD=100, then DUTY_TGT=10 with STEP=30.
   - Required: duty 100, then 70 → 40 → 10, then RUN.
6. Soft stop:
   - Stimulus: from RUN at duty 50 with STEP=25, write EN_REQ=0.
   - Required: STOP; duty 25 → 0; enable_o=0 and IDLE on the period_end_i where duty hits 0.
